// File: rtl/level_meter_refresh_scheduler.sv
// Merges left/right level-meter LED arrays into one {right,left} frame per refresh tick, blanking stale channels; also drives LED brightness PWM.
// Latency: a tick in cycle T presents o_valid in cycle T+1; o_pwm_on is one cycle behind the PWM counter.
// Backpressure: inputs never stall; a frame holds until o_ready, and ticks landing while it is pending are dropped and flagged on o_missed.
module level_meter_refresh_scheduler #(
    parameter int indicator_width       = 32,
    parameter int refresh_period_cycles = 500000,
    parameter int stale_ticks           = 8,
    parameter int brightness_bits       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         l_valid,
    output logic                         l_ready,
    input  logic [indicator_width-1:0]   l_array,
    input  logic                         r_valid,
    output logic                         r_ready,
    input  logic [indicator_width-1:0]   r_array,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [2*indicator_width-1:0] o_data,
    output logic                         o_missed,
    input  logic [brightness_bits-1:0]   brightness,
    output logic                         o_pwm_on
);

    localparam int TW = $clog2(refresh_period_cycles);
    localparam int SW = $clog2(stale_ticks + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(refresh_period_cycles - 1);
    localparam logic [SW-1:0] STALE_MAX = SW'(stale_ticks);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic                       rdy_q;
    logic                       l_cap;
    logic                       r_cap;
    logic [indicator_width-1:0] shadow_l;
    logic [indicator_width-1:0] shadow_r;
    logic [SW-1:0]              stale_l;
    logic [SW-1:0]              stale_r;
    logic [TW-1:0]              timer;
    logic                       tick;
    logic [indicator_width-1:0] frame_l;
    logic [indicator_width-1:0] frame_r;
    logic                       load_frame;
    state_t                     state_q;
    state_t                     state_d;
    logic [brightness_bits-1:0] pwm_cnt;
    logic [brightness_bits-1:0] duty;

    assign l_ready = rdy_q;
    assign r_ready = rdy_q;
    assign l_cap   = l_valid & rdy_q;
    assign r_cap   = r_valid & rdy_q;
    assign tick    = (timer == TIMER_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdy_q <= 1'b0;
            timer <= '0;
        end else begin
            rdy_q <= 1'b1;
            timer <= tick ? '0 : timer + 1'b1;
        end
    end

    // A capture always wins over the tick increment, so a channel refreshed on the tick is never aged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_l <= '0;
            shadow_r <= '0;
            stale_l  <= STALE_MAX;
            stale_r  <= STALE_MAX;
        end else begin
            if (l_cap) begin
                shadow_l <= l_array;
                stale_l  <= '0;
            end else if (tick && stale_l != STALE_MAX) begin
                stale_l  <= stale_l + 1'b1;
            end
            if (r_cap) begin
                shadow_r <= r_array;
                stale_r  <= '0;
            end else if (tick && stale_r != STALE_MAX) begin
                stale_r  <= stale_r + 1'b1;
            end
        end
    end

    assign frame_l = (stale_l < STALE_MAX) ? shadow_l : '0;
    assign frame_r = (stale_r < STALE_MAX) ? shadow_r : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            o_data  <= '0;
        end else begin
            state_q <= state_d;
            if (load_frame) begin
                o_data <= {frame_r, frame_l};
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        load_frame = 1'b0;
        o_valid    = 1'b0;
        o_missed   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    load_frame = 1'b1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                o_valid  = 1'b1;
                o_missed = tick;
                if (o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Duty only changes at the counter wrap so a brightness update never truncates a lit period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt  <= '0;
            duty     <= '0;
            o_pwm_on <= 1'b0;
        end else begin
            pwm_cnt  <= pwm_cnt + 1'b1;
            if (&pwm_cnt) begin
                duty <= brightness;
            end
            o_pwm_on <= (pwm_cnt < duty);
        end
    end

endmodule
